// File: rtl/adder_tree_accum.sv
// Windowed accumulator behind the registered adder-tree sum: adds ACC_COUNT samples and
// presents each total on a valid/ready register. Define ADDER_ACC_SAT_EN for saturating adds.
module adder_tree_accum #(
    parameter int unsigned ADDER_WIDTH = 8,
    parameter int unsigned ACC_COUNT   = 4,
    parameter int unsigned ACC_WIDTH   = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   in_valid,
    input  logic [ADDER_WIDTH:0]   in_sum,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_acc,
    output logic                   out_sat
);

    localparam int unsigned CNT_W = (ACC_COUNT > 1) ? $clog2(ACC_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_COUNT - 1);

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0] out_acc_q, out_acc_d;

    logic [ACC_WIDTH-1:0] in_ext;
    logic [ACC_WIDTH-1:0] add_res;
    logic                 last_c;
    logic                 accept_c;

    assign in_ext   = ACC_WIDTH'(in_sum);
    assign last_c   = (cnt_q == CNT_LAST);
    // Only the final sample of a window can stall, and only while the old total is unconsumed
    assign in_ready = !(last_c && out_valid_q && !out_ready);
    assign accept_c = in_valid && in_ready;

`ifdef ADDER_ACC_SAT_EN
    logic                 sat_q, sat_d;
    logic                 out_sat_q, out_sat_d;
    logic [ACC_WIDTH:0]   sum_full;
    logic                 clamp_c;

    assign sum_full = {1'b0, acc_q} + {1'b0, in_ext};
    assign clamp_c  = sum_full[ACC_WIDTH];
    assign add_res  = clamp_c ? {ACC_WIDTH{1'b1}} : sum_full[ACC_WIDTH-1:0];
    assign out_sat  = out_sat_q;
`else
    assign add_res  = acc_q + in_ext;
    assign out_sat  = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;

    // Next-state: output handshake first, then clear/accept may override
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
`ifdef ADDER_ACC_SAT_EN
        sat_d       = sat_q;
        out_sat_d   = out_sat_q;
`endif
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
`ifdef ADDER_ACC_SAT_EN
            sat_d = 1'b0;
`endif
            if (accept_c) begin
                acc_d = in_ext;
                cnt_d = CNT_W'(1);
            end
        end else if (accept_c) begin
            if (last_c) begin
                out_valid_d = 1'b1;
                out_acc_d   = add_res;
                acc_d       = '0;
                cnt_d       = '0;
`ifdef ADDER_ACC_SAT_EN
                out_sat_d   = sat_q || clamp_c;
                sat_d       = 1'b0;
`endif
            end else begin
                acc_d = add_res;
                cnt_d = cnt_q + CNT_W'(1);
`ifdef ADDER_ACC_SAT_EN
                sat_d = sat_q || clamp_c;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
        end
    end

`ifdef ADDER_ACC_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q     <= 1'b0;
            out_sat_q <= 1'b0;
        end else begin
            sat_q     <= sat_d;
            out_sat_q <= out_sat_d;
        end
    end
`endif

endmodule

// File: tb/tb_adder_tree_accum.sv
// Directed bench for adder_tree_accum: vector table plus hand-written reset and width cases.
module tb_adder_tree_accum;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        clear, in_valid, out_ready;
    logic [8:0]  in_sum;
    logic        in_ready, out_valid, out_sat;
    logic [10:0] out_acc;

    logic        clear_b, in_valid_b, out_ready_b;
    logic [8:0]  in_sum_b;
    logic        in_ready_b, out_valid_b, out_sat_b;
    logic [9:0]  out_acc_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    adder_tree_accum #(.ADDER_WIDTH(8), .ACC_COUNT(4), .ACC_WIDTH(11)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_sum(in_sum),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_sat(out_sat)
    );

    adder_tree_accum #(.ADDER_WIDTH(8), .ACC_COUNT(4), .ACC_WIDTH(10)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear_b), .in_valid(in_valid_b), .in_sum(in_sum_b),
        .in_ready(in_ready_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_acc(out_acc_b), .out_sat(out_sat_b)
    );

    typedef struct {
        logic        v;
        logic [8:0]  s;
        logic        r;
        logic        c;
        logic        exp_ir;
        logic        exp_ov;
        logic [10:0] exp_acc;
        logic        exp_sat;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic v, input int s, input logic r, input logic c,
                                input logic ir, input logic ov, input int acc);
        vec_t e;
        e.v = v; e.s = 9'(s); e.r = r; e.c = c;
        e.exp_ir = ir; e.exp_ov = ov; e.exp_acc = 11'(acc); e.exp_sat = 1'b0;
        vecs.push_back(e);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic feed_a(input logic v, input int s, input logic r, input logic c);
        in_valid = v; in_sum = 9'(s); out_ready = r; clear = c;
        @(posedge clk); #1;
    endtask

    initial begin
        // Test 1: basic window with sink ready
        add(1, 10, 1, 0, 1, 0, 0);
        add(1, 20, 1, 0, 1, 0, 0);
        add(1, 30, 1, 0, 1, 0, 0);
        add(1, 40, 1, 0, 1, 1, 100);
        add(0, 0,  1, 0, 1, 0, 0);
        // Test 2: 12 back-to-back full-scale samples
        for (int i = 0; i < 12; i++) add(1, 511, 1, 0, 1, (i % 4) == 3, 2044);
        add(0, 0, 1, 0, 1, 0, 0);
        // Test 3: pending result stalls only the final sample
        add(1, 100, 0, 0, 1, 0, 0);
        add(1, 100, 0, 0, 1, 0, 0);
        add(1, 100, 0, 0, 1, 0, 0);
        add(1, 100, 0, 0, 1, 1, 400);
        add(1, 1,   0, 0, 1, 1, 400);
        add(1, 2,   0, 0, 1, 1, 400);
        add(1, 3,   0, 0, 1, 1, 400);
        add(1, 4,   0, 0, 0, 1, 400);
        add(1, 4,   0, 0, 0, 1, 400);
        add(1, 4,   1, 0, 1, 1, 10);
        add(0, 0,   1, 0, 1, 0, 0);
        // Test 4: clear with accept restarts the window
        add(1, 5, 1, 0, 1, 0, 0);
        add(1, 6, 1, 0, 1, 0, 0);
        add(1, 7, 1, 1, 1, 0, 0);
        add(1, 1, 1, 0, 1, 0, 0);
        add(1, 1, 1, 0, 1, 0, 0);
        add(1, 1, 1, 0, 1, 1, 10);
        add(0, 0, 1, 0, 1, 0, 0);
        // clear while stalled discards the window and reopens the input
        add(1, 1, 0, 0, 1, 0, 0);
        add(1, 1, 0, 0, 1, 0, 0);
        add(1, 1, 0, 0, 1, 0, 0);
        add(1, 1, 0, 0, 1, 1, 4);
        add(1, 2, 0, 0, 1, 1, 4);
        add(1, 2, 0, 0, 1, 1, 4);
        add(1, 2, 0, 0, 1, 1, 4);
        add(1, 9, 0, 1, 0, 1, 4);
        add(1, 3, 0, 0, 1, 1, 4);
        add(0, 0, 1, 0, 1, 0, 0);
        add(1, 3, 1, 0, 1, 0, 0);
        add(1, 3, 1, 0, 1, 0, 0);
        add(1, 3, 1, 0, 1, 1, 12);
        add(0, 0, 1, 0, 1, 0, 0);
        // clear+accept at cnt==3 suppresses the window end
        add(1, 1, 1, 0, 1, 0, 0);
        add(1, 1, 1, 0, 1, 0, 0);
        add(1, 1, 1, 0, 1, 0, 0);
        add(1, 5, 1, 1, 1, 0, 0);
        add(1, 1, 1, 0, 1, 0, 0);
        add(1, 1, 1, 0, 1, 0, 0);
        add(1, 1, 1, 0, 1, 1, 8);
        add(0, 0, 1, 0, 1, 0, 0);

        rst_n = 1'b0;
        clear = 0; in_valid = 0; in_sum = '0; out_ready = 1;
        clear_b = 0; in_valid_b = 0; in_sum_b = '0; out_ready_b = 1;
        #12 rst_n = 1'b1;
        @(posedge clk); #1;

        check("reset_out_valid", 0, 32'(out_valid), 0);
        check("reset_out_acc",   0, 32'(out_acc),   0);
        check("reset_out_sat",   0, 32'(out_sat),   0);
        check("reset_in_ready",  0, 32'(in_ready),  1);

        for (int i = 0; i < vecs.size(); i++) begin
            in_valid = vecs[i].v; in_sum = vecs[i].s; out_ready = vecs[i].r; clear = vecs[i].c;
            #1;
            check("in_ready", i, 32'(in_ready), 32'(vecs[i].exp_ir));
            @(posedge clk); #1;
            check("out_valid", i, 32'(out_valid), 32'(vecs[i].exp_ov));
            if (vecs[i].exp_ov) begin
                check("out_acc", i, 32'(out_acc), 32'(vecs[i].exp_acc));
                check("out_sat", i, 32'(out_sat), 32'(vecs[i].exp_sat));
            end
        end
        in_valid = 0; clear = 0;

        // Test 5: 10-bit accumulator, four full-scale samples
        for (int i = 0; i < 4; i++) begin
            in_valid_b = 1; in_sum_b = 9'd511; out_ready_b = 1;
            @(posedge clk); #1;
        end
        in_valid_b = 0;
        check("narrow_out_valid", 0, 32'(out_valid_b), 1);
`ifdef ADDER_ACC_SAT_EN
        check("narrow_out_acc", 0, 32'(out_acc_b), 1023);
        check("narrow_out_sat", 0, 32'(out_sat_b), 1);
`else
        check("narrow_out_acc", 0, 32'(out_acc_b), 1020);
        check("narrow_out_sat", 0, 32'(out_sat_b), 0);
`endif
        @(posedge clk); #1;
        check("narrow_drain", 0, 32'(out_valid_b), 0);

        // Test 6: asynchronous reset with a pending result and a partial window
        for (int i = 0; i < 6; i++) feed_a(1, 1, 0, 0);
        in_valid = 0;
        check("pre_reset_valid", 0, 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", 0, 32'(out_valid), 0);
        check("async_reset_acc",   0, 32'(out_acc),   0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) feed_a(1, 1, 1, 0);
        in_valid = 0;
        check("post_reset_valid", 0, 32'(out_valid), 1);
        check("post_reset_acc",   0, 32'(out_acc),   4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_tree_accum.md
Name: adder_tree_accum

Overview:
- Downstream consumer of the registered adder-tree `sum` output.
- Accumulates ACC_COUNT consecutive tree results into one windowed total.
- Presents each total on a valid/ready output register.
- Lets the tree stream continuously while a finished total waits for the sink; the input side stalls only when a second window would overwrite an unconsumed result.

Parameters:
- ADDER_WIDTH, 8, operand width of the tree leaves; the input is ADDER_WIDTH+1 bits (registered tree sum).
- ACC_COUNT, 4, samples per window; power of two, at least 2.
- ACC_WIDTH, 11, accumulator and output width; at least ADDER_WIDTH+1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort of the partial window.
- in_valid  in  1  in_sum is valid this cycle.
- in_sum  in  ADDER_WIDTH+1  tree sum, unsigned.
- in_ready  out  1  block accepts in_sum this cycle.
- out_valid  out  1  out_acc holds a completed window total.
- out_ready  in  1  sink takes out_acc this cycle.
- out_acc  out  ACC_WIDTH  window total.
- out_sat  out  1  window total saturated (see Optional Feature).

Interface (already decided):
- One clock; reset is asynchronous and active-low.
- Clock port is clk; reset port is rst_n.

Behaviour:
- Reset (rst_n low, asynchronous): acc=0, cnt=0, out_valid=0, out_acc=0, out_sat=0, sat_sticky=0. in_ready goes to 1 once reset is released.
- Accept: in_valid && in_ready at a clk edge. Input is zero-extended; acc <= acc + in_sum (mod 2^ACC_WIDTH unless SAT); cnt <= cnt+1.
- Window end: an accept with cnt==ACC_COUNT-1. On that edge:
  - out_acc <= acc + in_sum (the final sample is included).
  - out_valid <= 1; out_sat <= sticky/sat result.
  - acc, cnt and sat_sticky go to 0.
  - Latency: out_valid rises the cycle after the final accept.
- Output handshake:
  - out_valid && out_ready at an edge clears out_valid, unless a new window completes on the same edge, in which case the new result loads and out_valid stays 1.
  - out_acc and out_sat are stable while out_valid && !out_ready.
- in_ready = !(cnt==ACC_COUNT-1 && out_valid && !out_ready).
  - Samples 0..ACC_COUNT-2 of the next window are always accepted.
  - The final sample waits until the output register is free; no result is ever dropped.
  - in_ready is combinational from out_ready and registered state only (no path from in_valid).
- clear (synchronous): acc, cnt and sat_sticky go to 0. The pending output register is unaffected.
  - clear with an accept on the same edge: the window restarts with that sample (acc=in_sum, cnt=1); no window-end fires even if cnt was ACC_COUNT-1.
  - clear while in_ready=0: the window is discarded, so in_ready rises the next cycle.
- Wrap-around: cnt counts modulo ACC_COUNT. There is no idle gap between windows; back-to-back accepts give one result every ACC_COUNT cycles.
- Reset mid-window or mid-handshake: all state is discarded immediately and out_valid falls asynchronously.

Optional Feature:
- Macro: ADDER_ACC_SAT_EN.
- Defined:
  - Each add is acc + in_sum clamped to 2^ACC_WIDTH-1.
  - On any clamp in the window, sat_sticky is set.
  - out_sat at window end = sat_sticky OR clamp on the final add.
  - Once clamped, acc stays at full scale for the rest of the window.
- Undefined:
  - Adds wrap modulo 2^ACC_WIDTH.
  - out_sat is tied to 0 and sat_sticky is not built.

Test Plan:
1. Reset, then in_sum 10,20,30,40 on consecutive cycles with out_ready=1 → one cycle after the 40 is accepted, out_valid=1 with out_acc=100 and out_sat=0; out_valid=0 the following cycle.
2. 12 back-to-back samples of value 511 with out_ready=1 → three results of 2044 on a 4-cycle cadence; in_ready is held high throughout.
3. out_ready=0 with a result pending; feed 1,2,3,4 → in_ready drops when cnt==3, and 4 is held. Raise out_ready → the old result is consumed and 4 is accepted on the same edge. The next cycle out_acc=10.
4. Feed 5,6, then pulse clear together with in_sum=7 accepted, then feed 1,1,1 → out_acc=10 (7+1+1+1); the 5 and 6 are discarded.
5. ACC_WIDTH=10, four samples of 511:
   - with ADDER_ACC_SAT_EN → out_acc=1023, out_sat=1;
   - without it → out_acc=1020, out_sat=0.
6. Assert rst_n low while out_valid=1 and cnt=2 → out_valid=0 immediately. After release, 4 samples of 1 give out_acc=4.
